// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing: counters, syncs, active qualifier, strobes, frame count
module vga_sync_gen #(
  parameter int c_TOTAL_COLS  = 800,
  parameter int c_TOTAL_ROWS  = 525,
  parameter int c_ACTIVE_COLS = 640,
  parameter int c_ACTIVE_ROWS = 480,
  parameter int c_H_FRONT     = 16,
  parameter int c_H_SYNC      = 96,
  parameter int c_V_FRONT     = 10,
  parameter int c_V_SYNC      = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Pix_En,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Line_Start,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count
);

  // Counter wrap points and sync windows, sized to the 10-bit counters.
  localparam logic [9:0] c_COL_LAST   = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0] c_ROW_LAST   = 10'(c_TOTAL_ROWS - 1);
  localparam logic [9:0] c_COL_ACTIVE = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] c_ROW_ACTIVE = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] c_HS_FIRST   = 10'(c_ACTIVE_COLS + c_H_FRONT);
  localparam logic [9:0] c_HS_LAST    = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC - 1);
  localparam logic [9:0] c_VS_FIRST   = 10'(c_ACTIVE_ROWS + c_V_FRONT);
  localparam logic [9:0] c_VS_LAST    = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC - 1);

  // Reject timings whose back porch would be negative or whose counts overflow 10 bits.
  generate
    if (c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC > c_TOTAL_COLS) begin : g_bad_h_timing
      $error("vga_sync_gen: active + front + sync columns exceed total columns");
    end
    if (c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC > c_TOTAL_ROWS) begin : g_bad_v_timing
      $error("vga_sync_gen: active + front + sync rows exceed total rows");
    end
    if (c_TOTAL_COLS > 1024 || c_TOTAL_ROWS > 1024 || c_TOTAL_COLS < 2 || c_TOTAL_ROWS < 1)
    begin : g_bad_range
      $error("vga_sync_gen: total columns/rows must fit the 10-bit counters");
    end
    if (c_H_SYNC < 1 || c_V_SYNC < 1) begin : g_bad_sync
      $error("vga_sync_gen: sync pulses must be at least one unit wide");
    end
  endgenerate

  logic       col_wrap;
  logic       row_wrap;
  logic [9:0] col_d;
  logic [9:0] row_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       active_d;
  logic       line_start_d;
  logic       frame_start_d;

  // Next pixel position; decodes use it so registered outputs line up with the counts.
  always_comb begin
    col_wrap = (o_Col_Count == c_COL_LAST);
    row_wrap = (o_Row_Count == c_ROW_LAST);
    col_d    = col_wrap ? 10'd0 : o_Col_Count + 10'd1;
    row_d    = o_Row_Count;
    if (col_wrap) begin
      row_d = row_wrap ? 10'd0 : o_Row_Count + 10'd1;
    end
  end

  // Sync, qualifier and strobe decode of the next pixel position.
  always_comb begin
    hsync_d       = !((col_d >= c_HS_FIRST) && (col_d <= c_HS_LAST));
    vsync_d       = !((row_d >= c_VS_FIRST) && (row_d <= c_VS_LAST));
    active_d      = (col_d < c_COL_ACTIVE) && (row_d < c_ROW_ACTIVE);
    line_start_d  = (col_d == 10'd0);
    frame_start_d = line_start_d && (row_d == 10'd0);
  end

  // Raster state: advances on enabled edges, strobes are dropped on disabled ones.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Col_Count   <= c_COL_LAST;
      o_Row_Count   <= c_ROW_LAST;
      o_HSync       <= 1'b1;
      o_VSync       <= 1'b1;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= 8'd0;
    end else if (i_Pix_En) begin
      o_Col_Count   <= col_d;
      o_Row_Count   <= row_d;
      o_HSync       <= hsync_d;
      o_VSync       <= vsync_d;
      o_Active      <= active_d;
      o_Line_Start  <= line_start_d;
      o_Frame_Start <= frame_start_d;
      if (frame_start_d) begin
        o_Frame_Count <= o_Frame_Count + 8'd1;
      end
    end else begin
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen (reduced raster)
module tb_vga_sync_gen;
  // Reduced raster: 20x12 total, 12x8 active, HSync cols 14..16, VSync rows 9..10, 240 px/frame.
  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic [9:0] col;
  logic [9:0] row;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  vga_sync_gen #(
    .c_TOTAL_COLS (20), .c_TOTAL_ROWS (12),
    .c_ACTIVE_COLS(12), .c_ACTIVE_ROWS(8),
    .c_H_FRONT    (2),  .c_H_SYNC     (3),
    .c_V_FRONT    (1),  .c_V_SYNC     (2)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Pix_En     (pix_en),
    .o_HSync      (hsync),
    .o_VSync      (vsync),
    .o_Col_Count  (col),
    .o_Row_Count  (row),
    .o_Active     (active),
    .o_Line_Start (line_start),
    .o_Frame_Start(frame_start),
    .o_Frame_Count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c, input int r, input int bound, input string tag);
    int n = 0;
    while (!(col == 10'(c) && row == 10'(r)) && n < bound) begin
      tick();
      n++;
    end
    check(tag, (col == 10'(c) && row == 10'(r)) ? 1 : 0, 1);
  endtask

  initial begin
    int fs_cyc, n, bad, hs_low, vs_low, act_n, prev_col, prev_row, prev_fc, wraps;
    rst_n  = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values hold while enabled clocks run.
    check("rst_col", col, 19);
    check("rst_row", row, 11);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_active", active, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_count", frame_count, 0);

    // First enabled edge lands on (0,0) with both strobes.
    rst_n = 1'b1;
    tick();
    fs_cyc = cyc;
    check("first_col", col, 0);
    check("first_row", row, 0);
    check("first_active", active, 1);
    check("first_line_start", line_start, 1);
    check("first_frame_start", frame_start, 1);
    check("first_frame_count", frame_count, 1);
    check("first_hsync", hsync, 1);
    tick();
    check("second_col", col, 1);
    check("second_line_start", line_start, 0);
    check("second_frame_start", frame_start, 0);
    check("second_frame_count", frame_count, 1);

    // Horizontal edges within row 0.
    repeat (10) tick();
    check("col11_col", col, 11);
    check("col11_active", active, 1);
    tick();
    check("col12_active", active, 0);
    tick();
    check("col13_hsync", hsync, 1);
    tick();
    check("col14_hsync", hsync, 0);
    repeat (2) tick();
    check("col16_hsync", hsync, 0);
    tick();
    check("col17_hsync", hsync, 1);
    repeat (3) tick();
    check("line2_col", col, 0);
    check("line2_row", row, 1);
    check("line2_line_start", line_start, 1);
    check("line2_frame_start", frame_start, 0);
    check("line_period", cyc - fs_cyc, 20);

    // Rest of the frame: tally sync/active cycles until the next frame start.
    n = 0; bad = 0; hs_low = 0; vs_low = 0; act_n = 0; prev_col = 0; prev_row = 0;
    // Row 0 already contributed 12 active cycles and 3 HSync-low cycles.
    act_n = 12; hs_low = 3;
    while (!frame_start && n < 1000) begin
      if (!hsync) begin
        hs_low++;
        if (col < 14 || col > 16) bad++;
      end
      if (!vsync) begin
        vs_low++;
        if (row < 9 || row > 10) bad++;
      end
      if (active) begin
        act_n++;
        if (col >= 12 || row >= 8) bad++;
      end
      if (line_start && col != 0) bad++;
      prev_col = col;
      prev_row = row;
      tick();
      n++;
    end
    check("frame_found", frame_start, 1);
    check("frame_period", cyc - fs_cyc, 240);
    check("wrap_prev_col", prev_col, 19);
    check("wrap_prev_row", prev_row, 11);
    check("wrap_col", col, 0);
    check("wrap_row", row, 0);
    check("hsync_low_cycles", hs_low, 36);
    check("vsync_low_cycles", vs_low, 40);
    check("active_cycles", act_n, 96);
    check("decode_out_of_range", bad, 0);
    check("frame_count_2", frame_count, 2);

    // Alternate disabled/enabled clocks for one frame.
    fs_cyc = cyc; n = 0; bad = 0;
    do begin
      prev_col = col;
      prev_row = row;
      pix_en = (n % 2 == 1);
      tick();
      n++;
      if (n % 2 == 1) begin
        if (line_start || frame_start) bad++;
        if (col != 10'(prev_col) || row != 10'(prev_row)) bad++;
      end
    end while (!frame_start && n < 2000);
    pix_en = 1'b1;
    check("toggle_frame_period", cyc - fs_cyc, 480);
    check("toggle_disabled_bad", bad, 0);
    check("toggle_frame_count", frame_count, 3);

    // Run to the Frame_Count wrap and check every increment on the way.
    n = 0; bad = 0; wraps = 0; prev_fc = frame_count;
    while (n < 70000 && wraps == 0) begin
      tick();
      n++;
      if (frame_start) begin
        if (frame_count != 8'(prev_fc + 1)) bad++;
        if (frame_count == 8'd0) begin
          wraps = 1;
          check("wrap_from_255", prev_fc, 255);
        end
        prev_fc = frame_count;
      end else if (frame_count != 8'(prev_fc)) bad++;
    end
    check("frame_count_wrapped", wraps, 1);
    check("frame_count_steps_bad", bad, 0);
    check("frames_to_wrap_cycles", n, 253 * 240);

    // Asynchronous reset mid-frame, then restart.
    run_to(15, 5, 300, "reach_15_5");
    check("pre_rst_hsync", hsync, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_col", col, 19);
    check("async_row", row, 11);
    check("async_hsync", hsync, 1);
    check("async_vsync", vsync, 1);
    check("async_active", active, 0);
    check("async_frame_count", frame_count, 0);
    check("async_strobes", {30'd0, line_start, frame_start}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("restart_col", col, 0);
    check("restart_row", row, 0);
    check("restart_frame_start", frame_start, 1);
    check("restart_frame_count", frame_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
